// File: rtl/reg_dump.sv
// reg_dump: debug readout engine for the CPU register file.
//
// A start pulse makes the block read every register address through the
// register file's spare read port. Each word is captured, then sent out on a
// valid/ready stream together with its address. A running XOR checksum of
// the captured words is kept.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a dump (only honoured in IDLE)
//   abort             terminate a dump in progress (FETCH/SEND)
//   rd_addr/rd_data   register-file read port (data combinational from addr)
//   m_valid/m_ready   stream handshake
//   m_data/m_index    captured word and the address it came from
//   m_last            marks the word for address NUM_REGS-1
//   busy              high in FETCH and SEND
//   done              one-cycle pulse after the last word is accepted
//   checksum          XOR of words captured in the current/most recent dump
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// FETCH | rd_addr = idx; word is captured at the closing edge
// SEND  | m_valid high, waiting for m_ready
// DONE  | done pulse, back to IDLE next cycle

module reg_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_index,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_m_index;
    logic [DATA_W-1:0]   r_m_data;
    logic [DATA_W-1:0]   r_checksum;
    logic                r_m_last;
    logic                w_hs;

    assign w_hs = (r_state == S_SEND) && m_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (abort) w_next = S_IDLE;
                else       w_next = S_SEND;
            end
            S_SEND: begin
                // abort wins over a same-cycle handshake: the word is dropped
                if (abort)         w_next = S_IDLE;
                else if (w_hs)     w_next = r_m_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // idx only changes on the edge that enters FETCH, so driving rd_addr
    // straight from it leaves rd_addr holding its last value elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_m_data   <= '0;
            r_m_index  <= '0;
            r_m_last   <= 1'b0;
            r_checksum <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx      <= '0;
                        r_checksum <= '0;
                    end
                end
                S_FETCH: begin
                    if (!abort) begin
                        r_m_data   <= rd_data;
                        r_m_index  <= r_idx;
                        r_m_last   <= (r_idx == LAST_IDX);
                        r_checksum <= r_checksum ^ rd_data;
                    end
                end
                S_SEND: begin
                    // increment only below the last index, so idx never wraps
                    if (!abort && w_hs && !r_m_last) r_idx <= r_idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign rd_addr  = r_idx;
    assign m_valid  = (r_state == S_SEND);
    assign m_data   = r_m_data;
    assign m_index  = r_m_index;
    assign m_last   = r_m_last;
    assign busy     = (r_state == S_FETCH) || (r_state == S_SEND);
    assign done     = (r_state == S_DONE);
    assign checksum = r_checksum;

endmodule
